// File: rtl/onehot_count_expander.sv
// onehot_count_expander
//   Inverse of the 4-input one-hot population counter. Accepts a one-hot
//   count code over valid/ready and regenerates the ones it represents, both
//   as a held thermometer word and as a serial train of single-cycle pulses.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   in_code is presented
//   in_ready   block can accept a code this cycle (only combinational output)
//   in_code    one-hot count, bit k set means count k (LANES+1 bits)
//   therm_out  thermometer word, low k bits set; held until next valid accept
//   count_out  binary count of the last accepted valid code
//   pulse_out  one pulse per counted one, first in the cycle after accept
//   busy       state is not IDLE
//   done       one-cycle strobe at the end of each valid code
//   err        sticky: a zero or multi-hot code was accepted
//   err_clr    synchronous clear of err (a same-cycle new error wins)
module onehot_count_expander #(
  parameter int LANES = 4,
  parameter int CW    = $clog2(LANES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES:0]   in_code,
  output logic [LANES-1:0] therm_out,
  output logic [CW-1:0]    count_out,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             err_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [LANES-1:0]  therm_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     rem_q;
  logic [CW-1:0]     rem_d;
  logic              pulse_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              accept;
  logic              code_hot;
  logic [CW-1:0]     code_k;
  logic [LANES-1:0]  code_therm;

  assign in_ready = (state_q == IDLE) & ~rst;
  assign accept   = in_valid & in_ready;
  assign rem_d    = rem_q - CW'(1);

  // Decode the incoming code. code_k is only meaningful when code_hot.
  always_comb begin
    code_hot   = (in_code != '0) && ((in_code & (in_code - 1'b1)) == '0);
    code_k     = '0;
    code_therm = '0;
    for (int unsigned i = 0; i <= LANES; i++) begin
      if (in_code[i]) code_k = CW'(i);
    end
    for (int unsigned i = 0; i < LANES; i++) begin
      code_therm[i] = (CW'(i) < code_k);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      therm_q <= '0;
      count_q <= '0;
      rem_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (err_clr) err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (code_hot) begin
              count_q <= code_k;
              therm_q <= code_therm;
              rem_q   <= code_k;
              busy_q  <= 1'b1;
              if (code_k != '0) begin
                state_q <= EMIT;
                pulse_q <= 1'b1;
              end else begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end else begin
              // Placed after the clear so a simultaneous error keeps err set.
              err_q <= 1'b1;
            end
          end
        end
        EMIT: begin
          rem_q <= rem_d;
          // pulse_out is registered, so the last pulse is the cycle where
          // rem_q is 1 and the decrement lands on zero.
          if (rem_q == CW'(1)) begin
            state_q <= DONE;
            pulse_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          pulse_q <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign therm_out = therm_q;
  assign count_out = count_q;
  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/onehot_count_expander.md
Name: onehot_count_expander

Overview:
- Inverse of the team's 4-input one-hot population counter.
- Accepts a one-hot count code over a valid/ready handshake and regenerates the ones it represents:
  - a thermometer-coded word with k ones, held until the next accepted code;
  - a serial train of exactly k single-cycle pulses.
- Sits downstream of the popcount adder. Used to reconstruct and check bit populations in self-test loops.

Parameters:
- LANES, 4, number of counted input bits. Code width is LANES+1; maximum count is LANES.
- CW, $clog2(LANES+1), width of the binary count output (3 at default).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_code is presented.
- in_ready  output  1  block can accept a code this cycle.
- in_code  input  LANES+1  one-hot count. Bit k set means count k. Bit 0 means zero ones; bit LANES means all ones.
- therm_out  output  LANES  thermometer word; the low k bits are set.
- count_out  output  CW  binary count of the last accepted valid code.
- pulse_out  output  1  serial pulse train, one pulse per counted one.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle strobe at the end of each code.
- err  output  1  sticky flag: a non-one-hot code was presented.
- err_clr  input  1  synchronous clear of err.

Behaviour:
- Reset (async, active-high): state=IDLE.
  - therm_out=0, count_out=0, pulse_out=0, done=0, err=0, remaining counter=0.
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after release.
- in_ready = (state==IDLE) & ~rst. This is the only combinational output. All other outputs are registered.
- States: IDLE, EMIT, DONE.
- IDLE, accept (in_valid & in_ready), code exactly one-hot with bit k:
  - count_out<=k, therm_out<=(1<<k)-1, remaining<=k.
  - Next state: EMIT if k>0, else DONE.
- IDLE, accept, code zero or multi-hot:
  - err<=1; code dropped.
  - therm_out and count_out unchanged; stay IDLE; no done.
- EMIT:
  - pulse_out=1 every cycle; remaining decrements.
  - Go to DONE when remaining reaches 0 after the decrement.
  - Exactly k consecutive pulses, the first in the cycle after accept.
- DONE: done=1 for one cycle, pulse_out=0, then IDLE.
- Latency and throughput:
  - Code with count k: accept cycle, k EMIT cycles, 1 DONE cycle. Next accept no earlier than k+2 cycles after the previous one.
  - k=0: done in the cycle after accept; next accept 2 cycles after the previous one.
- in_valid while busy: ignored, no side effects. The upstream block must hold the code until in_ready is seen.
- err:
  - err_clr=1 clears err next edge.
  - If err_clr and a new invalid accept occur in the same cycle, set wins: err stays 1.
  - err never blocks operation.
- Reset mid-operation: pulse_out, done and busy drop asynchronously. The partial train is abandoned and no done is issued.
- therm_out and count_out hold their value through EMIT and DONE, and until the next valid accept.

Test Plan:
- Reset release: after rst=1 then 0, outputs are all 0 and in_ready=1. Present in_code=5'b00000 with in_valid=1 -> err=1, done never asserts, therm_out=0.
- in_code=5'b01000 (k=3), accepted at cycle t:
  - pulse_out=1 at t+1..t+3, done=1 at t+4, in_ready=1 at t+5.
  - therm_out=4'b0111, count_out=3 from t+1.
- in_code=5'b00001 (k=0): no pulses, done=1 at t+1, therm_out=0, count_out=0. Then in_code=5'b10000 -> 4 pulses, therm_out=4'b1111, count_out=4.
- Multi-hot in_code=5'b00110 after a k=2 code:
  - err=1; therm_out stays 4'b0011.
  - err_clr together with a second invalid code -> err stays 1; err_clr alone -> err=0.
- Back-to-back: in_valid held high with k=2 then k=1 -> pulses in 2 then 1 cycles, each train followed by one done cycle. Second code accepted exactly 4 cycles after the first. No pulse is lost or duplicated.
- rst asserted during the 2nd pulse of a k=4 train -> pulse_out=0 immediately, no done, all outputs 0. After release a k=1 code produces exactly 1 pulse.
